div_sequencer: RTL and testbench
================================

# div_sequencer

Request/response controller that owns one `div_32b_unsigned` iterative divider core and turns it into a handshaked 32-bit divide unit. It supports signed and unsigned division, handles divide-by-zero without launching the core, and returns the quotient and remainder in `resp_lo` and `resp_hi`. It sits between the ALU issue logic and the core, sequencing the core's load (its `rst_n`) and its `enabled` input for exactly the required number of cycles.

## Interface
- No parameters; datapath width is fixed at 32.
- `clk` input 1 — clock; all logic on rising edge.
- `rst_n` input 1 — reset, synchronous, active-low.
- `req_valid` input 1 — request present.
- `req_ready` output 1 — high only in IDLE with `rst_n`=1.
- `req_signed` input 1 — 1 = signed (two's complement) divide, 0 = unsigned.
- `req_a` input 32 — dividend.
- `req_b` input 32 — divisor.
- `resp_valid` output 1 — result held valid.
- `resp_ready` input 1 — consumer accepts result.
- `resp_lo` output 32 — quotient.
- `resp_hi` output 32 — remainder.
- `resp_dbz` output 1 — divisor was zero.
- `resp_zero` output 1 — quotient == 0.
- `busy` output 1 — state != IDLE.

## Operation
- States: IDLE, LOAD, RUN, FIX, RESP.
- **IDLE**
  - Accept on `req_valid & req_ready`: latch `req_signed`, the operand signs, `|a|` and `|b|`.
  - For signed requests, use the magnitude of a negative operand. For unsigned requests, pass operands through.
  - If `req_b`==0: register `resp_lo`=0xFFFFFFFF, `resp_hi`=`req_a` (raw), `resp_dbz`=1, `resp_zero`=0, then go to RESP.
  - Otherwise go to LOAD.
- **LOAD** (1 cycle)
  - Drive core `rst_n`=0 with core `a`/`b` = latched magnitudes. The core loads its operands on this edge.
  - Go to RUN with iteration counter=0.
- **RUN**
  - Core `enabled`=1 for exactly 33 cycles (counter 0..32): 32 iterations plus 1 finalize cycle.
  - When counter==32, go to FIX.
  - `enabled` must never be high outside RUN. Extra enabled cycles corrupt the core's remainder.
- **FIX** (1 cycle)
  - Core `hi`/`lo` are valid.
  - Negate the quotient if the request was signed and the operand signs differ.
  - Negate the remainder if the request was signed and the dividend is negative.
  - Register `resp_lo`/`resp_hi`, set `resp_dbz`=0 and `resp_zero`=(quotient==0). Go to RESP.
- **RESP**
  - `resp_valid`=1. Result registers are stable until handshake.
  - On `resp_ready`, go to IDLE.
- Core `rst_n` = `rst_n` & (state != LOAD); the core's outputs are otherwise ignored.
- Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps; no flag).
- All arithmetic is modulo 2^32; negation is two's complement.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE, counter to 0; the core is held in reset.
  - `resp_valid`, `resp_lo`, `resp_hi`, `resp_dbz`, `resp_zero`, `busy` are all 0.
  - `req_ready`=0 while `rst_n`=0.
- Normal latency: with the accept edge as E0, `resp_valid` rises after edge E35. That is the LOAD edge E1, 33 RUN edges E2–E34, and the FIX edge E35.
- Divide-by-zero latency: `resp_valid` rises after E0 (1 cycle).
- Throughput: no overlap between operations. The next accept is possible the cycle after the response handshake. `req_ready`=0 during RESP even if `resp_ready`=1.
- Reset mid-operation (any state) aborts the operation; no response is produced. The next request after reset release behaves normally.
- `req_*` inputs are ignored outside IDLE; `resp_ready` is ignored outside RESP.

## Test plan
- Unsigned 100/7 → `resp_lo`=14, `resp_hi`=2, `resp_dbz`=0, `resp_zero`=0; `resp_valid` exactly 35 edges after accept.
- Signed 0xFFFFFFF9 (−7) / 2 → `resp_lo`=0xFFFFFFFD (−3), `resp_hi`=0xFFFFFFFF (−1); signed 7 / 0xFFFFFFFE → `resp_lo`=0xFFFFFFFD, `resp_hi`=1.
- Divide-by-zero, `req_a`=0x00001234, `req_b`=0 → `resp_lo`=0xFFFFFFFF, `resp_hi`=0x1234, `resp_dbz`=1, 1-cycle latency; core `enabled` never asserted.
- Signed 0x80000000 / 0xFFFFFFFF → `resp_lo`=0x80000000, `resp_hi`=0. Unsigned 3/5 → `resp_lo`=0, `resp_hi`=3, `resp_zero`=1.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid` → outputs stable, `req_ready`=0, `busy`=1. Release → IDLE the next cycle.
- Assert `rst_n`=0 at RUN counter 10, release, then issue unsigned 0xFFFFFFFF/1 → `resp_lo`=0xFFFFFFFF, `resp_hi`=0; no stale response emitted.

Source files
------------

// File: rtl/div_sequencer.sv
// Handshaked 32-bit signed/unsigned divide unit wrapping an iterative restoring divider core.
// The sequencer loads the core through its reset, then enables it for exactly 33 cycles.

module div_32b_unsigned (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enabled,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [5:0]  step_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Steps 0..31 are restoring iterations; step 32 publishes hi/lo. Any further
  // enabled cycle keeps shifting and ruins the remainder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= a;
      dvs_q  <= b;
      step_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (enabled) begin
      if (step_q == 6'd32) begin
        hi_q <= rem_q;
        lo_q <= quo_q;
      end else if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      step_q <= step_q + 6'd1;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// state | meaning
// IDLE  | waiting for a request; req_ready high
// LOAD  | core held in reset so it captures |a| and |b|
// RUN   | core enabled, counter 0..32 (32 iterations + finalize)
// FIX   | apply result signs and register the response
// RESP  | response held until resp_ready
module div_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_lo,
  output logic [31:0] resp_hi,
  output logic        resp_dbz,
  output logic        resp_zero,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic        dbz_r;
  logic        zero_r;

  logic        core_rst_n;
  logic        core_en;
  logic        core_load;
  logic [31:0] core_hi;
  logic [31:0] core_lo;

  logic        accept;
  logic        in_a_neg;
  logic        in_b_neg;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_en    = 1'b0;
    core_load  = 1'b0;
    resp_valid = 1'b0;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          if (req_b == 32'd0) state_nxt = RESP;
          else                state_nxt = LOAD;
        end
      end
      LOAD: begin
        core_load = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        core_en = 1'b1;
        if (cnt == 6'd32) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = req_valid & req_ready;
    in_a_neg = req_signed & req_a[31];
    in_b_neg = req_signed & req_b[31];
    quo_fix  = (op_signed && (a_neg ^ b_neg)) ? (32'd0 - core_lo) : core_lo;
    rem_fix  = (op_signed && a_neg) ? (32'd0 - core_hi) : core_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_signed <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      dbz_r     <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            op_signed <= req_signed;
            a_neg     <= in_a_neg;
            b_neg     <= in_b_neg;
            mag_a     <= in_a_neg ? (32'd0 - req_a) : req_a;
            mag_b     <= in_b_neg ? (32'd0 - req_b) : req_b;
            // Divide-by-zero answers straight away; the core is never started.
            if (req_b == 32'd0) begin
              lo_r   <= 32'hFFFF_FFFF;
              hi_r   <= req_a;
              dbz_r  <= 1'b1;
              zero_r <= 1'b0;
            end
          end
        end
        LOAD: cnt <= '0;
        RUN:  cnt <= cnt + 6'd1;
        FIX: begin
          cnt    <= '0;
          lo_r   <= quo_fix;
          hi_r   <= rem_fix;
          dbz_r  <= 1'b0;
          zero_r <= (quo_fix == 32'd0);
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign core_rst_n = rst_n & ~core_load;
  assign busy       = (state != IDLE);
  assign resp_lo    = lo_r;
  assign resp_hi    = hi_r;
  assign resp_dbz   = dbz_r;
  assign resp_zero  = zero_r;

  div_32b_unsigned u_core (
    .clk     (clk),
    .rst_n   (core_rst_n),
    .enabled (core_en),
    .a       (mag_a),
    .b       (mag_b),
    .hi      (core_hi),
    .lo      (core_lo)
  );

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: arithmetic results, latency, enable count,
// backpressure and mid-operation reset.

module tb_div_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_lo;
  logic [31:0] resp_hi;
  logic        resp_dbz;
  logic        resp_zero;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int lat;
  int en0;
  logic [31:0] hold_lo;
  logic [31:0] hold_hi;
  logic        saw_valid;

  div_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_lo    (resp_lo),
    .resp_hi    (resp_hi),
    .resp_dbz   (resp_dbz),
    .resp_zero  (resp_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (dut.core_en === 1'b1) en_cnt <= en_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then count edges until resp_valid.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int latency);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_signed = s;
    req_a      = a;
    req_b      = b;
    tick();
    req_valid  = 1'b0;
    req_a      = 32'hDEAD_BEEF;
    req_b      = 32'h0BAD_F00D;
    latency    = 0;
    while (resp_valid !== 1'b1 && latency < 100) begin
      tick();
      latency++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("valid_after_handshake", {31'd0, resp_valid}, 32'd0);
    check("ready_after_handshake", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lo", resp_lo, 32'd0);
    check("rst_hi", resp_hi, 32'd0);
    check("rst_flags", {30'd0, resp_dbz, resp_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    // unsigned 100 / 7
    en0 = en_cnt;
    issue(1'b0, 32'd100, 32'd7, lat);
    check("u100_7_latency", lat, 32'd35);
    check("u100_7_lo", resp_lo, 32'd14);
    check("u100_7_hi", resp_hi, 32'd2);
    check("u100_7_flags", {30'd0, resp_dbz, resp_zero}, 32'd0);
    check("u100_7_en_cycles", en_cnt - en0, 32'd33);
    finish_resp();

    // signed -7 / 2
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    check("s_m7_2_lo", resp_lo, 32'hFFFF_FFFD);
    check("s_m7_2_hi", resp_hi, 32'hFFFF_FFFF);
    finish_resp();

    // signed 7 / -2
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    check("s_7_m2_lo", resp_lo, 32'hFFFF_FFFD);
    check("s_7_m2_hi", resp_hi, 32'd1);
    finish_resp();

    // divide by zero
    en0 = en_cnt;
    issue(1'b0, 32'h0000_1234, 32'd0, lat);
    check("dbz_latency", lat, 32'd0);
    check("dbz_lo", resp_lo, 32'hFFFF_FFFF);
    check("dbz_hi", resp_hi, 32'h0000_1234);
    check("dbz_flags", {30'd0, resp_dbz, resp_zero}, 32'd2);
    check("dbz_no_enable", en_cnt - en0, 32'd0);
    finish_resp();

    // signed overflow case wraps
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("s_ovf_lo", resp_lo, 32'h8000_0000);
    check("s_ovf_hi", resp_hi, 32'd0);
    check("s_ovf_flags", {30'd0, resp_dbz, resp_zero}, 32'd0);
    finish_resp();

    // unsigned 3 / 5 with backpressure
    issue(1'b0, 32'd3, 32'd5, lat);
    check("u3_5_lo", resp_lo, 32'd0);
    check("u3_5_hi", resp_hi, 32'd3);
    check("u3_5_zero", {31'd0, resp_zero}, 32'd1);
    hold_lo = resp_lo;
    hold_hi = resp_hi;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_lo", resp_lo, hold_lo);
      check("bp_hi", resp_hi, hold_hi);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);

    // reset at RUN counter 10: accept E0, LOAD E1, counter 10 after E11
    req_valid  = 1'b1;
    req_signed = 1'b0;
    req_a      = 32'd1000;
    req_b      = 32'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid === 1'b1) saw_valid = 1'b1;
    end
    check("no_stale_resp", {31'd0, saw_valid}, 32'd0);

    en0 = en_cnt;
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, lat);
    check("post_rst_latency", lat, 32'd35);
    check("post_rst_lo", resp_lo, 32'hFFFF_FFFF);
    check("post_rst_hi", resp_hi, 32'd0);
    check("post_rst_en_cycles", en_cnt - en0, 32'd33);
    finish_resp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
